alu_result_demux_1to16: RTL and testbench
=========================================

Name: alu_result_demux_1to16

Overview:
- Registered 1-to-16 demultiplexer for the ALU result path; the counterpart of the 16-to-1 operand/result selector.
- Accepts one result word per cycle on a valid/ready input stream and steers it to one of 16 output channels, or broadcasts it to all 16.
- Each output channel has its own valid/ready handshake and a 1-entry holding register.
- Sits between the ALU result bus and the per-destination consumers (register-file write ports, flag logic, debug taps).

Parameters:
IN_WIDTH, 32, data word width per channel
CNT_WIDTH, 16, width of the accepted-transaction counter

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  input word present
in_ready  output  1  block can accept the input word this cycle
in_data  input  IN_WIDTH  input word
in_sel  input  4  destination channel 0..15; ignored when in_bcast=1
in_bcast  input  1  deliver in_data to all 16 channels
out_valid  output  16  bit i: channel i holds a valid word
out_ready  input  16  bit i: consumer i accepts channel i this cycle
out_data  output  16*IN_WIDTH  channel i word at [i*IN_WIDTH +: IN_WIDTH]
acc_count  output  CNT_WIDTH  number of accepted input transfers, wraps

Behaviour:
- Reset (rst=1 at a clk edge): out_valid=0, out_data=0, acc_count=0. Held words are discarded, including mid-transfer. in_ready follows the formula below from the reset state, so it reads 1 while out_valid=0.
- free[i] = !out_valid[i] || out_ready[i]. This is combinational.
- in_ready = in_bcast ? AND of free[15:0] : free[in_sel]. This is combinational and must not depend on in_valid.
- Input transfer = in_valid && in_ready at a clk edge.
- Unicast transfer, latency 1:
  - Channel in_sel loads in_data; out_valid[in_sel]=1 next cycle.
  - No other channel changes, apart from its own drain.
- Broadcast transfer:
  - All 16 channels load in_data; all out_valid bits are 1 next cycle.
  - The transfer is allowed only when every channel is free.
- Channel i drain (out_valid[i] && out_ready[i]) with no load the same cycle: out_valid[i] clears next cycle; out_data slice keeps its last value.
- Drain and load on the same channel in the same cycle: out_valid[i] stays 1 and the slice takes the new word. This gives full throughput of one word per cycle per channel.
- While out_valid[i]=1 and out_ready[i]=0, the slice and out_valid[i] are held stable. Input stalls only if it targets that channel, or if it is a broadcast.
- in_sel and in_data are don't-care when in_valid=0. in_sel is don't-care when in_bcast=1.
- acc_count increments by 1 per input transfer (unicast or broadcast).
  - Wraps from 2^CNT_WIDTH-1 to 0.
  - Updates the cycle after the transfer.
- No internal FSM beyond the per-channel full/empty bit. No word is ever dropped or duplicated, except by reset.
- out_ready toggling while out_valid[i]=0 has no effect.

Test Plan:
- Reset, then in_valid=1, in_sel=5, in_data=32'hDEADBEEF, out_ready=16'h0000:
  - Cycle+1: out_valid=16'h0020, slice 5=DEADBEEF, acc_count=1.
  - A second word to sel=5 sees in_ready=0.
  - A word to sel=6 is accepted.
- Back-to-back streaming to sel=3, out_ready[3]=1, words 1,2,3,4 on consecutive cycles:
  - in_ready stays 1.
  - out_data slice 3 shows 1,2,3,4 one cycle later, out_valid[3] continuously 1.
  - acc_count=4.
- Broadcast 32'h0000_00A5 with channel 9 full and out_ready[9]=0:
  - in_ready=0.
  - Raise out_ready[9]: in_ready=1, transfer occurs; next cycle all 16 slices=A5, out_valid=16'hFFFF.
- Backpressure hold: channel 12 loaded with 32'h12345678, out_ready[12]=0 for 10 cycles while other channels stream:
  - Slice 12 and out_valid[12] are unchanged throughout.
- Reset mid-operation: several channels valid, assert rst=1 for one cycle:
  - Next cycle out_valid=0, all out_data=0, acc_count=0, in_ready=1.
- Counter wrap with CNT_WIDTH=4: 17 unicast transfers -> acc_count reads 15 after the 15th, 0 after the 16th, 1 after the 17th.

Source files
------------

// File: rtl/alu_result_demux_1to16.sv
// alu_result_demux_1to16: registered 1-to-16 result demux with per-channel 1-entry holding registers and broadcast
module alu_result_demux_1to16 #(
  parameter int IN_WIDTH  = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [IN_WIDTH-1:0]    in_data,
  input  logic [3:0]             in_sel,
  input  logic                   in_bcast,
  output logic [15:0]            out_valid,
  input  logic [15:0]            out_ready,
  output logic [16*IN_WIDTH-1:0] out_data,
  output logic [CNT_WIDTH-1:0]   acc_count
);
  logic [15:0]               free, load, vld_d, vld_q;
  logic [15:0][IN_WIDTH-1:0] data_q;
  logic [CNT_WIDTH-1:0]      cnt_q;
  logic                      xfer;
  assign free      = ~vld_q | out_ready;
  assign in_ready  = in_bcast ? &free : free[in_sel];
  assign xfer      = in_valid & in_ready;
  assign load      = !xfer ? '0 : in_bcast ? '1 : 16'(1) << in_sel;
  // a drained channel stays valid only if it is reloaded in the same cycle
  assign vld_d     = load | (vld_q & ~out_ready);
  assign out_valid = vld_q;
  assign out_data  = data_q;
  assign acc_count = cnt_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= '0;
      cnt_q  <= '0;
      data_q <= '0;
    end else begin
      vld_q <= vld_d;
      cnt_q <= cnt_q + CNT_WIDTH'(xfer);
      for (int i = 0; i < 16; i++)
        if (load[i]) data_q[i] <= in_data;
    end
  end
endmodule

// File: tb/tb_alu_result_demux_1to16.sv
// tb_alu_result_demux_1to16: directed and random steps checked against an array-based channel model
module tb_alu_result_demux_1to16;
  localparam int W = 32;
  logic clk = 1'b0;
  logic rst, in_valid, in_bcast, in_ready, in_ready4;
  logic [3:0] in_sel, acc_count4;
  logic [W-1:0] in_data;
  logic [15:0] out_ready, out_valid, out_valid4, acc_count;
  logic [16*W-1:0] out_data, out_data4;
  int checks = 0, errors = 0;
  bit mvld[16];
  logic [W-1:0] mdat[16];
  int mcnt;
  always #5 clk = ~clk;

  alu_result_demux_1to16 #(.IN_WIDTH(W), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sel(in_sel), .in_bcast(in_bcast), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .acc_count(acc_count));

  alu_result_demux_1to16 #(.IN_WIDTH(W), .CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data),
    .in_sel(in_sel), .in_bcast(in_bcast), .out_valid(out_valid4), .out_ready(out_ready),
    .out_data(out_data4), .acc_count(acc_count4));

  task automatic chk(string tag, logic [W-1:0] obs, logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_ready(int sel, bit bc, logic [15:0] ordy);
    bit all_free = 1'b1;
    for (int i = 0; i < 16; i++) if (mvld[i] && !ordy[i]) all_free = 1'b0;
    return bc ? all_free : (!mvld[sel] || ordy[sel]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin mvld[i] = 0; mdat[i] = '0; end
    mcnt = 0;
  endtask

  task automatic check_state();
    logic [15:0] v;
    for (int i = 0; i < 16; i++) v[i] = mvld[i];
    chk("out_valid", W'(out_valid), W'(v));
    for (int i = 0; i < 16; i++) chk($sformatf("slice%0d", i), out_data[i*W +: W], mdat[i]);
    chk("acc_count", W'(acc_count), W'(mcnt % 65536));
    chk("acc_count4", W'(acc_count4), W'(mcnt % 16));
  endtask

  task automatic step(bit r, bit iv, int sel, logic [W-1:0] d, bit bc, logic [15:0] ordy);
    bit rdy;
    rst = r; in_valid = iv; in_sel = 4'(sel); in_data = d; in_bcast = bc; out_ready = ordy;
    #1;
    rdy = model_ready(sel, bc, ordy);
    chk("in_ready", W'(in_ready), W'(rdy));
    chk("in_ready4", W'(in_ready4), W'(rdy));
    @(posedge clk);
    if (r) model_reset();
    else begin
      for (int i = 0; i < 16; i++) if (mvld[i] && ordy[i]) mvld[i] = 0;
      if (iv && rdy) begin
        for (int i = 0; i < 16; i++) if (bc || i == sel) begin mvld[i] = 1; mdat[i] = d; end
        mcnt++;
      end
    end
    #1;
    check_state();
  endtask

  initial begin
    rst = 1; in_valid = 0; in_sel = 0; in_data = '0; in_bcast = 0; out_ready = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_state();
    chk("reset_in_ready", W'(in_ready), 32'd1);
    step(0, 1, 5, 32'hDEADBEEF, 0, 16'h0000);
    chk("uni_valid", W'(out_valid), 32'h0020);
    chk("uni_slice5", out_data[5*W +: W], 32'hDEADBEEF);
    chk("uni_cnt", W'(acc_count), 32'd1);
    step(0, 1, 5, 32'h11111111, 0, 16'h0000);
    step(0, 1, 6, 32'h66666666, 0, 16'h0000);
    chk("sel6_valid", W'(out_valid), 32'h0060);
    step(0, 0, 0, '0, 0, 16'hFFFF);
    for (int k = 1; k <= 4; k++) begin
      step(0, 1, 3, W'(k), 0, 16'h0008);
      chk("stream_slice3", out_data[3*W +: W], W'(k));
      chk("stream_vld3", W'(out_valid[3]), 32'd1);
    end
    step(0, 1, 9, 32'h99, 0, 16'h0000);
    step(0, 0, 0, '0, 0, ~16'h0200);
    step(0, 1, 0, 32'hA5, 1, 16'h0000);
    chk("bcast_stall_vld", W'(out_valid), 32'h0200);
    step(0, 1, 0, 32'hA5, 1, 16'h0200);
    chk("bcast_valid", W'(out_valid), 32'hFFFF);
    for (int i = 0; i < 16; i++) chk("bcast_slice", out_data[i*W +: W], 32'hA5);
    step(0, 0, 0, '0, 0, 16'hFFFF);
    step(0, 1, 12, 32'h12345678, 0, 16'hFFFF);
    for (int k = 0; k < 10; k++) begin
      int s = $urandom_range(0, 11);
      step(0, 1, s, $urandom, 0, ~16'h1000);
      chk("hold_slice12", out_data[12*W +: W], 32'h12345678);
      chk("hold_vld12", W'(out_valid[12]), 32'd1);
    end
    step(1, 1, 2, 32'h5, 0, 16'h0000);
    chk("rst_valid", W'(out_valid), 32'd0);
    chk("rst_data", W'(|out_data), 32'd0);
    chk("rst_cnt", W'(acc_count), 32'd0);
    chk("rst_in_ready", W'(in_ready), 32'd1);
    for (int k = 1; k <= 17; k++) begin
      step(0, 1, $urandom_range(0, 15), $urandom, 0, 16'hFFFF);
      if (k == 15) chk("wrap15", W'(acc_count4), 32'd15);
      if (k == 16) chk("wrap16", W'(acc_count4), 32'd0);
      if (k == 17) chk("wrap17", W'(acc_count4), 32'd1);
    end
    for (int k = 0; k < 400; k++)
      step($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 15),
           $urandom, $urandom_range(0, 7) == 0, 16'($urandom));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
